neuron_mac: RTL and testbench



---
 rtl/neuron_mac.sv | 137 +++++++++++++
 tb/tb_neuron_mac.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/neuron_mac.sv
// neuron_mac: sequences one neuron's element fetch through extract_elements,
// multiply-accumulates the returned input/weight pairs, then adds bias,
// rescales from fixed point and applies optional ReLU plus saturation.
module neuron_mac #(
  parameter int resolution            = 8,
  parameter int input_data_size       = 4,
  parameter int input_data_size_width = $clog2(input_data_size),
  parameter int frac_bits             = 4,
  parameter bit relu_en               = 1'b1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic signed [resolution-1:0]     bias,
  input  logic signed [resolution-1:0]     input_data_element,
  input  logic signed [resolution-1:0]     weight_element,
  output logic                             extract_en,
  output logic [input_data_size_width-1:0] index,
  output logic                             busy,
  output logic                             done,
  output logic signed [resolution-1:0]     neuron_out
);

  localparam int prod_width = 2 * resolution;
  // Two guard bits on top of the index growth keep the sum of all products
  // plus the shifted bias from ever overflowing.
  localparam int acc_width  = 2 * resolution + input_data_size_width + 2;

  localparam logic [input_data_size_width-1:0] last_idx =
    input_data_size_width'(input_data_size - 1);
  localparam logic signed [acc_width-1:0] sat_max =
    acc_width'((1 <<< (resolution - 1)) - 1);
  localparam logic signed [acc_width-1:0] sat_min =
    acc_width'(-(1 <<< (resolution - 1)));

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

  state_t                           state_reg, state_next;
  logic [input_data_size_width-1:0] cnt_reg, cnt_next;
  logic                             acc_clear;
  logic                             valid_d_reg;
  logic signed [acc_width-1:0]      acc_reg;

  logic signed [prod_width-1:0]     product;
  logic signed [acc_width-1:0]      bias_ext;
  logic signed [acc_width-1:0]      sum;
  logic signed [acc_width-1:0]      shifted;
  logic signed [acc_width-1:0]      clamped;
  logic signed [resolution-1:0]     result;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic plus the fetch-side outputs driven to extract_elements.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    acc_clear  = 1'b0;
    extract_en = 1'b0;
    index      = '0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          cnt_next   = '0;
          acc_clear  = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        extract_en = 1'b1;
        index      = cnt_reg;
        busy       = 1'b1;
        cnt_next   = cnt_reg + 1'b1;
        if (cnt_reg == last_idx) state_next = DRAIN;
      end
      DRAIN: begin
        busy       = 1'b1;
        state_next = FINISH;
      end
      FINISH: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Element counter and the one-cycle-delayed valid matching the element latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg     <= '0;
      valid_d_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      valid_d_reg <= (state_reg == RUN);
    end
  end

  assign product = input_data_element * weight_element;

  // Accumulator: cleared when a neuron starts, adds one product per valid pair.
  always_ff @(posedge clk) begin
    if (reset || acc_clear) begin
      acc_reg <= '0;
    end else if (valid_d_reg) begin
      acc_reg <= acc_reg + {{(acc_width-prod_width){product[prod_width-1]}}, product};
    end
  end

  // Bias alignment, floor rescale, optional ReLU and saturation to the output width.
  always_comb begin
    bias_ext = {{(acc_width-resolution){bias[resolution-1]}}, bias};
    sum      = acc_reg + (bias_ext <<< frac_bits);
    shifted  = sum >>> frac_bits;
    clamped  = shifted;
    if (relu_en && shifted[acc_width-1]) clamped = '0;
    if (clamped > sat_max)      result = sat_max[resolution-1:0];
    else if (clamped < sat_min) result = sat_min[resolution-1:0];
    else                        result = clamped[resolution-1:0];
  end

  // Output register and done pulse, both updated on the edge leaving FINISH.
  always_ff @(posedge clk) begin
    if (reset) begin
      neuron_out <= '0;
      done       <= 1'b0;
    end else begin
      done <= (state_reg == FINISH);
      if (state_reg == FINISH) neuron_out <= result;
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: drives two neuron_mac instances (ReLU on and off) with the
// same stimulus, emulates the one-cycle element latency of extract_elements,
// and compares against an arithmetic model of the neuron.
module tb_neuron_mac;

  localparam int RES = 8;
  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int FB  = 4;

  logic clk = 1'b0;
  logic reset, start;
  logic signed [RES-1:0] bias, in_el, w_el;

  logic          ext_r, busy_r, done_r, ext_l, busy_l, done_l;
  logic [IW-1:0] idx_r, idx_l;
  logic signed [RES-1:0] out_r, out_l;

  int in_v[N];
  int w_v[N];
  int bias_v;
  int prev_r = 0;
  int prev_l = 0;
  int n_vec  = 0;
  int n_err  = 0;

  always #5 clk = ~clk;

  neuron_mac #(.resolution(RES), .input_data_size(N), .input_data_size_width(IW),
               .frac_bits(FB), .relu_en(1'b1)) dut_relu (
    .clk(clk), .reset(reset), .start(start), .bias(bias),
    .input_data_element(in_el), .weight_element(w_el),
    .extract_en(ext_r), .index(idx_r), .busy(busy_r), .done(done_r),
    .neuron_out(out_r));

  neuron_mac #(.resolution(RES), .input_data_size(N), .input_data_size_width(IW),
               .frac_bits(FB), .relu_en(1'b0)) dut_lin (
    .clk(clk), .reset(reset), .start(start), .bias(bias),
    .input_data_element(in_el), .weight_element(w_el),
    .extract_en(ext_l), .index(idx_l), .busy(busy_l), .done(done_l),
    .neuron_out(out_l));

  task automatic chk(input string tag, input string what,
                     input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s: observed %0d expected %0d", tag, what, obs, exp);
    end
  endtask

  // Neuron value straight from the arithmetic definition.
  function automatic int model(input bit relu);
    longint s;
    longint r;
    s = longint'(bias_v) * (64'sd1 <<< FB);
    for (int k = 0; k < N; k++) s += longint'(in_v[k]) * longint'(w_v[k]);
    r = s >>> FB;
    if (relu && r < 0) r = 0;
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return int'(r);
  endfunction

  task automatic set_vec(input int a, input int w, input int b);
    for (int k = 0; k < N; k++) begin
      in_v[k] = a;
      w_v[k]  = w;
    end
    bias_v = b;
  endtask

  task automatic set_random();
    for (int k = 0; k < N; k++) begin
      in_v[k] = int'($urandom_range(0, 255)) - 128;
      w_v[k]  = int'($urandom_range(0, 255)) - 128;
    end
    bias_v = int'($urandom_range(0, 255)) - 128;
  endtask

  // One idle cycle: nothing active, output held.
  task automatic idle_step(input string tag);
    @(negedge clk);
    chk(tag, "idle_extract_en", 32'(ext_r), 0);
    chk(tag, "idle_busy", 32'(busy_r), 0);
    chk(tag, "idle_done", 32'(done_r | done_l), 0);
    chk(tag, "idle_out_relu", 32'(out_r), prev_r);
    chk(tag, "idle_out_lin", 32'(out_l), prev_l);
    in_el = 8'($urandom);
    w_el  = 8'($urandom);
    bias  = 8'($urandom);
  endtask

  // Called at a negedge; raises start there and checks every following cycle
  // up to and including the done cycle. hold keeps start high while busy.
  task automatic run_neuron(input string tag, input bit hold);
    int er;
    int el;
    er = model(1'b1);
    el = model(1'b0);
    start = 1'b1;
    for (int j = 1; j <= N + 3; j++) begin
      @(negedge clk);
      chk(tag, "extract_en", 32'(ext_r), (j <= N) ? 1 : 0);
      chk(tag, "index", 32'(idx_r), (j <= N) ? j - 1 : 0);
      chk(tag, "busy", 32'(busy_r), (j <= N + 2) ? 1 : 0);
      chk(tag, "done_relu", 32'(done_r), (j == N + 3) ? 1 : 0);
      chk(tag, "done_lin", 32'(done_l), (j == N + 3) ? 1 : 0);
      chk(tag, "out_relu", 32'(out_r), (j == N + 3) ? er : prev_r);
      chk(tag, "out_lin", 32'(out_l), (j == N + 3) ? el : prev_l);
      start = hold && (j <= N + 1);
      in_el = (j >= 2 && j <= N + 1) ? 8'(in_v[j-2]) : 8'($urandom);
      w_el  = (j >= 2 && j <= N + 1) ? 8'(w_v[j-2])  : 8'($urandom);
      bias  = (j == N + 2) ? 8'(bias_v) : 8'($urandom);
    end
    prev_r = er;
    prev_l = el;
    $display("%s: relu_out=%0d lin_out=%0d (model %0d / %0d)", tag, out_r, out_l, er, el);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bias  = '0;
    in_el = '0;
    w_el  = '0;
    repeat (3) @(negedge clk);
    chk("reset", "extract_en", 32'(ext_r), 0);
    chk("reset", "index", 32'(idx_r), 0);
    chk("reset", "busy", 32'(busy_r), 0);
    chk("reset", "done", 32'(done_r), 0);
    chk("reset", "out_relu", 32'(out_r), 0);
    chk("reset", "out_lin", 32'(out_l), 0);
    reset = 1'b0;
    idle_step("post_reset");

    set_vec(16, 16, 0);     run_neuron("all16", 1'b0);        idle_step("all16");
    set_vec(16, -16, 0);    run_neuron("neg_weights", 1'b0);  idle_step("neg_weights");
    set_vec(127, 127, 0);   run_neuron("sat_pos", 1'b0);
    set_vec(127, -128, 0);  run_neuron("sat_neg_b2b", 1'b0);  idle_step("sat_neg_b2b");
    set_vec(0, 0, 32);      run_neuron("bias_only", 1'b0);    idle_step("bias_only");
    set_vec(16, 16, -80);   run_neuron("bias_neg", 1'b0);     idle_step("bias_neg");
    set_vec(16, 16, 0);     run_neuron("start_held", 1'b1);   idle_step("start_held");

    // Abort in the middle of RUN.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort", "extract_en", 32'(ext_r), 0);
    chk("abort", "index", 32'(idx_r), 0);
    chk("abort", "busy", 32'(busy_r), 0);
    chk("abort", "done", 32'(done_r), 0);
    chk("abort", "out_relu", 32'(out_r), 0);
    chk("abort", "out_lin", 32'(out_l), 0);
    $display("abort: reset mid-RUN, relu_out=%0d lin_out=%0d", out_r, out_l);
    prev_r = 0;
    prev_l = 0;
    for (int k = 0; k < N + 4; k++) idle_step("abort_quiet");
    set_vec(16, 16, 0);     run_neuron("after_abort", 1'b0);  idle_step("after_abort");

    for (int t = 0; t < 24; t++) begin
      set_random();
      run_neuron($sformatf("rand%0d", t), t[0]);
      if (t % 3 != 2) idle_step($sformatf("rand%0d", t));
    end
    idle_step("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
